// File: rtl/btn_irq_pkg.sv
// -----------------------------------------------------------------------------
// btn_irq_pkg
// Shared definitions for the push-button interrupt controller: debouncer state
// encoding, default widths, and the helper that sizes the debounce counter.
// Ports: none (package).
// -----------------------------------------------------------------------------
package btn_irq_pkg;

    localparam int DEFAULT_CNT_W           = 8;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

    typedef enum logic [1:0] {
        ST_LO,
        ST_CHK_HI,
        ST_HI,
        ST_CHK_LO
    } deb_state_e;

    // The counter only has to reach DEBOUNCE_CYCLES-1, so clog2 bits suffice.
    function automatic int debounce_w(input int cycles);
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/btn_irq_ctrl_if.sv
// -----------------------------------------------------------------------------
// btn_irq_ctrl_if
// Bundles the button input, the core-side irq/ack handshake and the status
// outputs of btn_irq_ctrl.
//   btn_i      raw asynchronous button level
//   irq_en_i   event enable (0 = accepted edges are discarded)
//   irq_ack_i  one-cycle ack from the core, consumes one pending event
//   irq_o      interrupt request, high while pend_cnt_o != 0
//   pend_cnt_o pending-event count
//   level_o    debounced button level
//   ovf_o      sticky overflow flag
// Modports: master = board/core side, slave = btn_irq_ctrl.
// -----------------------------------------------------------------------------
interface btn_irq_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             btn_i;
    logic             irq_en_i;
    logic             irq_ack_i;
    logic             irq_o;
    logic [CNT_W-1:0] pend_cnt_o;
    logic             level_o;
    logic             ovf_o;

    modport master (
        output btn_i, irq_en_i, irq_ack_i,
        input  irq_o, pend_cnt_o, level_o, ovf_o
    );

    modport slave (
        input  btn_i, irq_en_i, irq_ack_i,
        output irq_o, pend_cnt_o, level_o, ovf_o
    );
endinterface

// File: rtl/btn_irq_ctrl_sync_debounce.sv
// -----------------------------------------------------------------------------
// sync_debounce
// Two-flop synchroniser followed by a stable-count debouncer. A new level is
// accepted after DEBOUNCE_CYCLES consecutive identical synchronised samples;
// rise_o/fall_o pulse for one cycle, coincident with the level_o change.
//   clk      system clock
//   reset    asynchronous active-high reset
//   btn_i    raw asynchronous input
//   level_o  debounced level
//   rise_o   one-cycle pulse on an accepted 0->1
//   fall_o   one-cycle pulse on an accepted 1->0
// -----------------------------------------------------------------------------
module sync_debounce
    import btn_irq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int                    DEBOUNCE_W = debounce_w(DEBOUNCE_CYCLES);
    localparam logic [DEBOUNCE_W-1:0] CNT_LAST   = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEBOUNCE_W-1:0] CNT_ONE    = DEBOUNCE_W'(1);

    logic                  s1_q, s2_q;
    deb_state_e            state_q, state_d;
    logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;
    logic                  level_q, level_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of its source; blocking here would collapse s1/s2 into one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn_i;
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path can leave a value unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LO: begin
                if (s2_q) begin
                    state_d = ST_CHK_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_CHK_HI: begin
                if (!s2_q) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HI: begin
                if (!s2_q) begin
                    state_d = ST_CHK_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_CHK_LO: begin
                if (s2_q) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_LO;
                cnt_d   = '0;
            end
        endcase
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/btn_irq_ctrl.sv
// -----------------------------------------------------------------------------
// btn_irq_ctrl
// Turns the raw BTNC line into a level-sensitive external interrupt request:
// synchronise + debounce, gate accepted edges with irq_en_i, accumulate them in
// a saturating pending counter that the core drains with irq_ack_i.
//   clk    system clock (divided CLK100MHZ)
//   reset  asynchronous active-high reset
//   bus    btn_irq_ctrl_if.slave: btn_i, irq_en_i, irq_ack_i in;
//          irq_o, pend_cnt_o, level_o, ovf_o out
// Build option: define BTN_IRQ_BOTH_EDGES_EN to count releases as well as
// presses; by default only presses generate events.
// -----------------------------------------------------------------------------
module btn_irq_ctrl
    import btn_irq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic           clk,
    input  logic           reset,
    btn_irq_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             rise, fall, ev;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sync_debounce (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (bus.btn_i),
        .level_o (bus.level_o),
        .rise_o  (rise),
        .fall_o  (fall)
    );

`ifdef BTN_IRQ_BOTH_EDGES_EN
    // rise and fall come from mutually exclusive FSM transitions, so this is
    // never more than one event per cycle.
    assign ev = (rise | fall) & bus.irq_en_i;
`else
    assign ev = rise & bus.irq_en_i;
    logic unused_fall;
    assign unused_fall = fall;
`endif

    // An event and an ack in the same cycle cancel; saturation only flags
    // overflow when an event would actually have been added.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (ev && !bus.irq_ack_i) begin
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (!ev && bus.irq_ack_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.irq_o      = (cnt_q != '0);
    assign bus.pend_cnt_o = cnt_q;
    assign bus.ovf_o      = ovf_q;

endmodule
